// File: rtl/cosim_stim_pkg.sv
// Shared types and constants for the co-simulation stimulus sequencer.
package cosim_stim_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_RST1 = 3'd1,
    PH_GAP1 = 3'd2,
    PH_RAND = 3'd3,
    PH_RST2 = 3'd4,
    PH_GAP2 = 3'd5,
    PH_DIR  = 3'd6,
    PH_DONE = 3'd7
  } phase_t;

  localparam logic [31:0] SEED_DEFAULT     = 32'h0000_0001;
  localparam logic [31:0] TAPS_DEFAULT     = 32'h8020_0003;
  localparam logic [31:0] DIRECTED_DEFAULT = 32'hABCD_EFAB;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cosim_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and step enable.
module cosim_lfsr32
  import cosim_stim_pkg::*;
#(
  parameter logic [31:0] SEED = SEED_DEFAULT,
  parameter logic [31:0] TAPS = TAPS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [31:0] nxt_c
);

  // An all-zero state would lock the register up, so a zero seed becomes 1.
  localparam logic [31:0] SEED_SAFE = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0] q;

  always_comb begin
    nxt_c = q;
    if (rst || load) begin
      nxt_c = SEED_SAFE;
    end else if (step) begin
      nxt_c = (q >> 1) ^ (q[0] ? TAPS : 32'd0);
    end
  end

  always_ff @(posedge clk) begin
    q <= nxt_c;
  end

endmodule

// File: rtl/cosim_stim_sequencer.sv
// Reusable stimulus generator: DUT reset, LFSR vectors, second reset, one
// directed vector, with a compare strobe on the last cycle of each hold.
module cosim_stim_sequencer
  import cosim_stim_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_RANDOM = 1000,
  parameter int unsigned HOLD       = 2,
  parameter logic [31:0] SEED       = SEED_DEFAULT,
  parameter logic [31:0] TAPS       = TAPS_DEFAULT,
  parameter logic [31:0] DIRECTED   = DIRECTED_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                dut_rst,
  output logic [WIDTH-1:0]                    stim,
  output logic                                cmp_en,
  output logic [2:0]                          phase,
  output logic [clog2(NUM_RANDOM+1)-1:0]      vec_idx,
  output logic                                done
);

  localparam int unsigned VW = clog2(NUM_RANDOM + 1);
  localparam int unsigned HW = clog2(HOLD + 1);
  localparam logic [HW-1:0] HC_LAST = HW'(HOLD - 1);
  localparam logic [VW-1:0] VI_LAST = VW'(NUM_RANDOM - 1);

  phase_t          state_q, state_d;
  logic [HW-1:0]   hc_q, hc_d;
  logic [VW-1:0]   vi_d;
  logic            hold_last;
  logic            lfsr_load, lfsr_step;
  logic [31:0]     lfsr_nxt;
  logic            dut_rst_d, cmp_en_d, done_d;
  logic [WIDTH-1:0] stim_d;

  cosim_lfsr32 #(
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .nxt_c (lfsr_nxt)
  );

  // Next state, counters and the output values that the next state implies.
  always_comb begin
    state_d   = state_q;
    hc_d      = hc_q;
    vi_d      = vec_idx;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    hold_last = (hc_q == HC_LAST);

    unique case (state_q)
      PH_IDLE, PH_DONE: begin
        if (start) begin
          state_d   = PH_RST1;
          hc_d      = '0;
          vi_d      = '0;
          lfsr_load = 1'b1;
        end
      end
      PH_RST1: begin
        if (hold_last) begin
          state_d = PH_GAP1;
          hc_d    = '0;
        end else begin
          hc_d = hc_q + HW'(1);
        end
      end
      PH_GAP1: state_d = PH_RAND;
      PH_RAND: begin
        if (hold_last) begin
          hc_d      = '0;
          lfsr_step = 1'b1;
          vi_d      = vec_idx + VW'(1);
          if (vec_idx == VI_LAST) state_d = PH_RST2;
        end else begin
          hc_d = hc_q + HW'(1);
        end
      end
      PH_RST2: begin
        if (hold_last) begin
          state_d = PH_GAP2;
          hc_d    = '0;
        end else begin
          hc_d = hc_q + HW'(1);
        end
      end
      PH_GAP2: state_d = PH_DIR;
      PH_DIR: begin
        if (hold_last) begin
          state_d = PH_DONE;
          hc_d    = '0;
        end else begin
          hc_d = hc_q + HW'(1);
        end
      end
      default: state_d = PH_IDLE;
    endcase

    dut_rst_d = state_d inside {PH_IDLE, PH_RST1, PH_RST2};
    done_d    = (state_d == PH_DONE);
    cmp_en_d  = (state_d inside {PH_RST1, PH_RAND, PH_RST2, PH_DIR}) && (hc_d == HC_LAST);
    stim_d    = '0;
    if (state_d == PH_RAND) begin
      stim_d = lfsr_nxt[WIDTH-1:0];
    end else if (state_d == PH_DIR) begin
      stim_d = DIRECTED[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PH_IDLE;
      hc_q    <= '0;
      vec_idx <= '0;
      dut_rst <= 1'b1;
      stim    <= '0;
      cmp_en  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      vec_idx <= vi_d;
      dut_rst <= dut_rst_d;
      stim    <= stim_d;
      cmp_en  <= cmp_en_d;
      done    <= done_d;
    end
  end

  assign phase = 3'(state_q);

endmodule

// File: tb/tb_cosim_stim_sequencer.sv
// Bench for cosim_stim_sequencer: two configurations driven in lockstep and
// checked every cycle against a position-in-run reference model.
module tb_cosim_stim_sequencer;
  import cosim_stim_pkg::*;

  localparam int unsigned NA = 4;
  localparam int unsigned HA = 2;
  localparam logic [31:0] SA = 32'h0000_0001;
  localparam int unsigned NZ = 3;
  localparam int unsigned HZ = 1;
  localparam logic [31:0] SZ = 32'h0000_0000;
  localparam int unsigned VWA = clog2(NA + 1);
  localparam int unsigned VWZ = clog2(NZ + 1);
  localparam int LA = 3 * HA + 2 + NA * HA;
  localparam int LZ = 3 * HZ + 2 + NZ * HZ;

  logic clk = 1'b0;
  logic rst, start;

  logic            a_dut_rst, a_cmp_en, a_done;
  logic [31:0]     a_stim;
  logic [2:0]      a_phase;
  logic [VWA-1:0]  a_vec_idx;
  logic            z_dut_rst, z_cmp_en, z_done;
  logic [31:0]     z_stim;
  logic [2:0]      z_phase;
  logic [VWZ-1:0]  z_vec_idx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cosim_stim_sequencer #(.WIDTH(32), .NUM_RANDOM(NA), .HOLD(HA), .SEED(SA)) dut_a (
    .clk(clk), .rst(rst), .start(start), .dut_rst(a_dut_rst), .stim(a_stim),
    .cmp_en(a_cmp_en), .phase(a_phase), .vec_idx(a_vec_idx), .done(a_done)
  );

  cosim_stim_sequencer #(.WIDTH(32), .NUM_RANDOM(NZ), .HOLD(HZ), .SEED(SZ)) dut_z (
    .clk(clk), .rst(rst), .start(start), .dut_rst(z_dut_rst), .stim(z_stim),
    .cmp_en(z_cmp_en), .phase(z_phase), .vec_idx(z_vec_idx), .done(z_done)
  );

  typedef struct packed {
    logic [2:0]  ph;
    logic        dr;
    logic [31:0] st;
    logic        ce;
    logic        dn;
    logic [15:0] vi;
  } exp_t;

  logic [2:0]  ph_tr [17] = '{1, 1, 2, 3, 3, 3, 3, 3, 3, 3, 3, 4, 4, 5, 6, 6, 7};
  logic [31:0] rand_tab [4] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_after(input logic [31:0] seed, input int k);
    logic [31:0] s;
    s = (seed == 32'd0) ? 32'd1 : seed;
    for (int i = 0; i < k; i++) s = (s >> 1) ^ (s[0] ? TAPS_DEFAULT : 32'd0);
    return s;
  endfunction

  // mode: 0 idle, 1 running (pos = cycles since start edge), 2 done.
  function automatic exp_t expect_at(input int mode, input int pos, input int n,
                                     input int h, input logic [31:0] seed);
    exp_t e;
    int p;
    e = '0;
    if (mode == 0) begin
      e.dr = 1'b1;
      return e;
    end
    if (mode == 2) begin
      e.ph = 3'd7; e.dn = 1'b1; e.vi = 16'(n);
      return e;
    end
    p = pos;
    if (p < h) begin
      e.ph = 3'd1; e.dr = 1'b1; e.ce = (p == h - 1);
      return e;
    end
    p -= h;
    if (p == 0) begin
      e.ph = 3'd2;
      return e;
    end
    p -= 1;
    if (p < n * h) begin
      e.ph = 3'd3; e.st = lfsr_after(seed, p / h); e.ce = (p % h == h - 1); e.vi = 16'(p / h);
      return e;
    end
    p -= n * h;
    e.vi = 16'(n);
    if (p < h) begin
      e.ph = 3'd4; e.dr = 1'b1; e.ce = (p == h - 1);
      return e;
    end
    p -= h;
    if (p == 0) begin
      e.ph = 3'd5;
      return e;
    end
    p -= 1;
    e.ph = 3'd6; e.st = DIRECTED_DEFAULT; e.ce = (p == h - 1);
    return e;
  endfunction

  task automatic model_step(inout int mode, inout int pos, input int len);
    if (rst) begin
      mode = 0;
    end else if (mode != 1 && start) begin
      mode = 1;
      pos  = 0;
    end else if (mode == 1) begin
      pos++;
      if (pos == len) mode = 2;
    end
  endtask

  int mode_a = 0, pos_a = 0, mode_z = 0, pos_z = 0;
  exp_t ea, ez;

  // Per-cycle scoreboard for both instances.
  always begin
    @(posedge clk);
    model_step(mode_a, pos_a, LA);
    model_step(mode_z, pos_z, LZ);
    #1;
    ea = expect_at(mode_a, pos_a, NA, HA, SA);
    ez = expect_at(mode_z, pos_z, NZ, HZ, SZ);
    check("a.phase",   64'(a_phase),   64'(ea.ph));
    check("a.dut_rst", 64'(a_dut_rst), 64'(ea.dr));
    check("a.stim",    64'(a_stim),    64'(ea.st));
    check("a.cmp_en",  64'(a_cmp_en),  64'(ea.ce));
    check("a.done",    64'(a_done),    64'(ea.dn));
    check("a.vec_idx", 64'(a_vec_idx), 64'(ea.vi));
    check("z.phase",   64'(z_phase),   64'(ez.ph));
    check("z.dut_rst", 64'(z_dut_rst), 64'(ez.dr));
    check("z.stim",    64'(z_stim),    64'(ez.st));
    check("z.cmp_en",  64'(z_cmp_en),  64'(ez.ce));
    check("z.done",    64'(z_done),    64'(ez.dn));
    check("z.vec_idx", 64'(z_vec_idx), 64'(ez.vi));
  end

  task automatic directed_run(input bit noisy);
    int  first_done;
    int  pulses;
    int  k;
    bit  seen_z;
    first_done = -1;
    pulses     = 0;
    k          = 0;
    seen_z     = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 22; c++) begin
      if (c < 17) check("a.phase_trace", 64'(a_phase), 64'(ph_tr[c]));
      if (a_done && first_done < 0) first_done = c;
      if (a_cmp_en) begin
        pulses++;
        if (a_phase == 3'd3 && k < 4) begin
          check("a.rand_vec", 64'(a_stim), 64'(rand_tab[k]));
          k++;
        end
      end
      if (!seen_z && z_phase == 3'd3) begin
        check("z.zero_seed", 64'(z_stim), 64'd1);
        seen_z = 1'b1;
      end
      if (noisy && c >= 3 && c <= 9) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("a.done_latency", 64'(first_done), 64'(LA));
    check("a.cmp_pulses",   64'(pulses),     64'(NA + 3));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    directed_run(1'b0);
    repeat (2) @(negedge clk);
    directed_run(1'b1);

    // Abort during the second random vector, then replay from the seed.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("a.abort_phase",   64'(a_phase),   64'd0);
    check("a.abort_dut_rst", 64'(a_dut_rst), 64'd1);
    check("a.abort_cmp_en",  64'(a_cmp_en),  64'd0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("a.replay_first", 64'(a_stim), 64'h1);
    repeat (LA) @(negedge clk);

    // Random starts, aborts and idle gaps.
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int j = 0; j < int'($urandom_range(0, LA + 3)); j++) begin
        start = ($urandom_range(0, 3) == 0);
        rst   = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      start = 1'b0;
      rst   = 1'b0;
    end
    repeat (LA + 2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
